// File: rtl/color_matrix_pipe_pkg.sv
// Shared constants and helpers for the colour matrix pipeline: default
// coefficient sets and coefficient-index encoding.
package color_matrix_pipe_pkg;

    localparam int NUM_COEF = 9;

    // RGB->LMS defaults in Q.13, row-major.
    function automatic int lms_default(input int idx);
        case (idx)
            0:       return 3122;
            1:       return 4737;
            2:       return 329;
            3:       return 1611;
            4:       return 5934;
            5:       return 641;
            6:       return 197;
            7:       return 1055;
            8:       return 6917;
            default: return 0;
        endcase
    endfunction

    function automatic int default_coef(input int set_i, input int idx, input int frac);
        if (set_i == 0) begin
            return lms_default(idx);
        end else if (idx == 0 || idx == 4 || idx == 8) begin
            return 1 << frac;
        end else begin
            return 0;
        end
    endfunction

    function automatic logic [3:0] cfg_idx(input int row, input int col);
        return 4'(row * 3 + col);
    endfunction

    function automatic logic cfg_idx_valid(input logic [3:0] idx);
        return idx < 4'd9;
    endfunction

endpackage

// File: rtl/color_matrix_pipe_if.sv
// Pixel stream, coefficient-config and output stream bundle for color_matrix_pipe.
interface color_matrix_pipe_if #(
    parameter int IN_W   = 8,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 16,
    parameter int SET_W  = 1
);
    logic              i_valid;
    logic              o_ready;
    logic [IN_W-1:0]   i_c0;
    logic [IN_W-1:0]   i_c1;
    logic [IN_W-1:0]   i_c2;
    logic [SET_W-1:0]  i_set;
    logic              i_cfg_we;
    logic [SET_W-1:0]  i_cfg_set;
    logic [3:0]        i_cfg_idx;
    logic [COEF_W-1:0] i_cfg_data;
    logic              o_valid;
    logic              i_ready;
    logic [OUT_W-1:0]  o_c0;
    logic [OUT_W-1:0]  o_c1;
    logic [OUT_W-1:0]  o_c2;
    logic [2:0]        o_sat;

    modport slave (
        input  i_valid, i_c0, i_c1, i_c2, i_set,
        input  i_cfg_we, i_cfg_set, i_cfg_idx, i_cfg_data, i_ready,
        output o_ready, o_valid, o_c0, o_c1, o_c2, o_sat
    );

    modport master (
        output i_valid, i_c0, i_c1, i_c2, i_set,
        output i_cfg_we, i_cfg_set, i_cfg_idx, i_cfg_data, i_ready,
        input  o_ready, o_valid, o_c0, o_c1, o_c2, o_sat
    );
endinterface

// File: rtl/color_matrix_pipe_row.sv
// One matrix row: sums three registered products, rounds half-up to the
// output fixed point and clamps to the unsigned output range with a flag.
module color_matrix_row #(
    parameter int IN_W      = 8,
    parameter int COEF_W    = 16,
    parameter int COEF_FRAC = 13,
    parameter int OUT_W     = 16,
    parameter int OUT_FRAC  = 8,
    parameter int PROD_W    = COEF_W + IN_W + 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic signed [PROD_W-1:0] i_p0,
    input  logic signed [PROD_W-1:0] i_p1,
    input  logic signed [PROD_W-1:0] i_p2,
    output logic [OUT_W-1:0]         o_c,
    output logic                     o_sat
);
    localparam int ACC_W = IN_W + COEF_W + 3;
    localparam int SH    = COEF_FRAC - OUT_FRAC;
    localparam int SH_M1 = (SH > 0) ? SH - 1 : 0;
    localparam logic signed [ACC_W-1:0] RND  = (SH > 0) ? (ACC_W'(1) <<< SH_M1) : '0;
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    logic signed [ACC_W-1:0] w_acc;
    logic signed [ACC_W-1:0] w_sh;
    logic [OUT_W-1:0]        w_c;
    logic                    w_sat;

    // Sum, round, shift and clamp.
    always_comb begin
        w_acc = ACC_W'(i_p0) + ACC_W'(i_p1) + ACC_W'(i_p2) + RND;
        w_sh  = w_acc >>> SH;
        if (w_sh[ACC_W-1]) begin
            w_c   = '0;
            w_sat = 1'b1;
        end else if (w_sh > MAXV) begin
            w_c   = '1;
            w_sat = 1'b1;
        end else begin
            w_c   = w_sh[OUT_W-1:0];
            w_sat = 1'b0;
        end
    end

    // Output register; holds while the pipeline is stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_c   <= '0;
            o_sat <= 1'b0;
        end else if (i_en) begin
            o_c   <= w_c;
            o_sat <= w_sat;
        end
    end

endmodule

// File: rtl/color_matrix_pipe.sv
// Two-stage 3x3 colour matrix with runtime-writable coefficient sets,
// per-pixel set select and valid/ready lockstep stall.
module color_matrix_pipe
    import color_matrix_pipe_pkg::*;
#(
    parameter int IN_W      = 8,
    parameter int COEF_W    = 16,
    parameter int COEF_FRAC = 13,
    parameter int OUT_W     = 16,
    parameter int OUT_FRAC  = 8,
    parameter int NUM_SETS  = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    color_matrix_pipe_if.slave bus
);
    localparam int SET_W  = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
    localparam int PROD_W = COEF_W + IN_W + 1;
    localparam logic [SET_W:0] NUM_SETS_V = (SET_W + 1)'(NUM_SETS);

    logic signed [COEF_W-1:0] r_coef [NUM_SETS][NUM_COEF];
    logic signed [PROD_W-1:0] r_prod [3][3];
    logic                     r_s1_valid;
    logic                     r_s2_valid;

    logic                     w_adv;
    logic                     w_cfg_hit;
    logic [SET_W-1:0]         w_set;
    logic signed [PROD_W-1:0] w_in_ext [3];
    logic signed [PROD_W-1:0] w_prod [3][3];
    logic [OUT_W-1:0]         w_oc [3];
    logic [2:0]               w_sat;

    // Lockstep stall: every stage moves only when the output slot frees up.
    assign w_adv       = !r_s2_valid || bus.i_ready;
    assign bus.o_ready = w_adv;
    assign bus.o_valid = r_s2_valid;

    // Out-of-range set selects fall back to set 0.
    always_comb begin
        if ({1'b0, bus.i_set} < NUM_SETS_V) begin
            w_set = bus.i_set;
        end else begin
            w_set = '0;
        end
        w_cfg_hit = bus.i_cfg_we && ({1'b0, bus.i_cfg_set} < NUM_SETS_V)
                    && cfg_idx_valid(bus.i_cfg_idx);
    end

    // Products of selected coefficients with zero-extended input channels.
    always_comb begin
        w_in_ext[0] = PROD_W'($signed({1'b0, bus.i_c0}));
        w_in_ext[1] = PROD_W'($signed({1'b0, bus.i_c1}));
        w_in_ext[2] = PROD_W'($signed({1'b0, bus.i_c2}));
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                w_prod[r][k] = PROD_W'(r_coef[w_set][4'(r * 3 + k)]) * w_in_ext[k];
            end
        end
    end

    // Coefficient register file; a write lands on the next edge so a pixel
    // accepted in the same cycle still sees the old value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int i = 0; i < NUM_COEF; i++) begin
                    r_coef[s][i] <= COEF_W'(default_coef(s, i, COEF_FRAC));
                end
            end
        end else if (w_cfg_hit) begin
            r_coef[bus.i_cfg_set][bus.i_cfg_idx] <= $signed(bus.i_cfg_data);
        end
    end

    // Stage 1: product registers and valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int k = 0; k < 3; k++) begin
                    r_prod[r][k] <= '0;
                end
            end
        end else if (w_adv) begin
            r_s1_valid <= bus.i_valid;
            if (bus.i_valid) begin
                for (int r = 0; r < 3; r++) begin
                    for (int k = 0; k < 3; k++) begin
                        r_prod[r][k] <= w_prod[r][k];
                    end
                end
            end
        end
    end

    // Stage 2 valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s2_valid <= 1'b0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_row
        color_matrix_row #(
            .IN_W      (IN_W),
            .COEF_W    (COEF_W),
            .COEF_FRAC (COEF_FRAC),
            .OUT_W     (OUT_W),
            .OUT_FRAC  (OUT_FRAC),
            .PROD_W    (PROD_W)
        ) u_row (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_en    (w_adv && r_s1_valid),
            .i_p0    (r_prod[g][0]),
            .i_p1    (r_prod[g][1]),
            .i_p2    (r_prod[g][2]),
            .o_c     (w_oc[g]),
            .o_sat   (w_sat[g])
        );
    end

    assign bus.o_c0  = w_oc[0];
    assign bus.o_c1  = w_oc[1];
    assign bus.o_c2  = w_oc[2];
    assign bus.o_sat = w_sat;

endmodule
